// File: rtl/score_round_controller.sv
// Sequences one timed scoring round (IDLE -> COUNTDOWN -> PLAY -> DONE), generating the sample
// strobe, accumulating a saturating hit score and tracking the session high score.
module score_round_controller #(
    parameter int SAMPLE_DIV      = 20000000,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 30,
    parameter int SCORE_MAX       = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       in,
    output logic [7:0] score,
    output logic [7:0] high_score,
    output logic [7:0] ticks_left,
    output logic [1:0] state,
    output logic       sample_tick,
    output logic       round_done
);

    localparam int               DIV_W     = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]       CD_INIT   = 8'(COUNTDOWN_TICKS);
    localparam logic [7:0]       PLAY_INIT = 8'(ROUND_TICKS);
    localparam logic [7:0]       SCORE_SAT = 8'(SCORE_MAX);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COUNTDOWN = 2'b01,
        PLAY      = 2'b10,
        DONE      = 2'b11
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic             start_q;
    logic             start_rise;
    logic [DIV_W-1:0] divider;
    logic             div_at_last;
    logic             div_run;
    logic             tick_now;
    logic             round_end;
    logic             state_enter;

    assign start_rise  = start & ~start_q;
    assign div_at_last = (divider == DIV_LAST);
    assign state_enter = (next_state != cur_state);
    assign state       = cur_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Pause only matters in PLAY; COUNTDOWN always runs the divider.
    always_comb begin
        next_state = cur_state;
        div_run    = 1'b0;
        tick_now   = 1'b0;
        round_end  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start_rise) begin
                    next_state = COUNTDOWN;
                end
            end
            COUNTDOWN: begin
                div_run  = 1'b1;
                tick_now = div_at_last;
                if (div_at_last && (ticks_left <= 8'd1)) begin
                    next_state = PLAY;
                end
            end
            PLAY: begin
                div_run  = ~pause;
                tick_now = ~pause & div_at_last;
                // The final tick leaves ticks_left at 0; close the round one cycle later.
                if (ticks_left == 8'd0) begin
                    next_state = DONE;
                    round_end  = 1'b1;
                end
            end
            DONE: begin
                if (start_rise) begin
                    next_state = COUNTDOWN;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            start_q     <= 1'b0;
            divider     <= '0;
            sample_tick <= 1'b0;
            round_done  <= 1'b0;
            score       <= 8'd0;
            high_score  <= 8'd0;
            ticks_left  <= 8'd0;
        end else begin
            start_q     <= start;
            sample_tick <= tick_now;
            round_done  <= round_end;

            if (state_enter || tick_now || (cur_state == IDLE) || (cur_state == DONE)) begin
                divider <= '0;
            end else if (div_run) begin
                divider <= divider + 1'b1;
            end

            if (state_enter && (next_state == COUNTDOWN)) begin
                ticks_left <= CD_INIT;
            end else if (state_enter && (next_state == PLAY)) begin
                ticks_left <= PLAY_INIT;
            end else if (tick_now && (ticks_left != 8'd0)) begin
                ticks_left <= ticks_left - 8'd1;
            end

            if (state_enter && (next_state == COUNTDOWN)) begin
                score <= 8'd0;
            end else if ((cur_state == PLAY) && tick_now && in && (score < SCORE_SAT)) begin
                score <= score + 8'd1;
            end

            if (round_end && (score > high_score)) begin
                high_score <= score;
            end
        end
    end

endmodule

// File: tb/tb_score_round_controller.sv
// Randomized round stimulus with a transaction-level expected-event scoreboard.
module tb_score_round_controller;

    localparam int DIV       = 4;
    localparam int CT        = 2;
    localparam int RT        = 5;
    localparam int SMAX      = 3;
    localparam int ROUND_CYC = (CT + RT) * DIV + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       in    = 1'b0;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [7:0] ticks_left;
    logic [1:0] state;
    logic       sample_tick;
    logic       round_done;

    int tests    = 0;
    int fails    = 0;
    int cyc      = 0;
    int hs_model = 0;

    typedef struct {
        bit done;
        int st;
        int tl;
        int sc;
        int hs;
        int at;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    score_round_controller #(
        .SAMPLE_DIV(DIV),
        .COUNTDOWN_TICKS(CT),
        .ROUND_TICKS(RT),
        .SCORE_MAX(SMAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .pause(pause),
        .in(in),
        .score(score),
        .high_score(high_score),
        .ticks_left(ticks_left),
        .state(state),
        .sample_tick(sample_tick),
        .round_done(round_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe or round-end pulse consumes one expected event.
    always @(negedge clock) begin
        if (!reset && (sample_tick || round_done)) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: tick=%0b done=%0b, expected no event", sample_tick, round_done);
            end else begin
                mon_e = sbq.pop_front();
                check("event_kind", round_done, mon_e.done);
                check("event_state", state, mon_e.st);
                check("event_ticks_left", ticks_left, mon_e.tl);
                check("event_score", score, mon_e.sc);
                if (mon_e.done) begin
                    check("done_high_score", high_score, mon_e.hs);
                    check("done_cycle", cyc, mon_e.at);
                end
            end
        end
    end

    task automatic wait_tick(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clock);
            #1;
            if (sample_tick) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: no sample_tick within 64 cycles, expected one", name);
        end
    endtask

    // stop_at > 0 returns right after that many PLAY ticks (no DONE expected).
    task automatic run_round(input logic [RT-1:0] hv, input int pcyc, input bit hold, input int stop_at);
        int   sum;
        int   psum;
        int   pafter;
        int   t0;
        int   n_play;
        int   final_sc;
        bit   ok;
        exp_t e;
        n_play = (stop_at > 0) ? stop_at : RT;
        pafter = (pcyc > 0) ? int'($urandom_range(1, RT - 1)) : 0;
        start  = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b1;
        t0    = cyc;

        e.done = 1'b0;
        e.hs   = 0;
        e.at   = 0;
        for (int k = 1; k <= CT; k++) begin
            e.st = (k < CT) ? 1 : 2;
            e.tl = (k < CT) ? CT - k : RT;
            e.sc = 0;
            sbq.push_back(e);
        end
        sum  = 0;
        psum = 0;
        for (int j = 1; j <= n_play; j++) begin
            sum += int'(hv[j-1]);
            if (j == pafter) psum = (sum < SMAX) ? sum : SMAX;
            e.st = 2;
            e.tl = RT - j;
            e.sc = (sum < SMAX) ? sum : SMAX;
            sbq.push_back(e);
        end
        final_sc = e.sc;
        if (stop_at == 0) begin
            e.done   = 1'b1;
            e.st     = 3;
            e.tl     = 0;
            e.hs     = (final_sc > hs_model) ? final_sc : hs_model;
            e.at     = t0 + ROUND_CYC + pcyc;
            hs_model = e.hs;
            sbq.push_back(e);
        end

        @(posedge clock);
        #1;
        check("enter_state", state, 1);
        check("enter_ticks_left", ticks_left, CT);
        check("enter_score", score, 0);

        // in and pause are noise during COUNTDOWN; pause is dropped before PLAY begins.
        for (int k = 1; k <= CT; k++) begin
            in    = 1'($urandom_range(0, 1));
            pause = (k < CT) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!hold) start = 1'($urandom_range(0, 1));
            wait_tick("countdown_tick", ok);
            if (!ok) return;
        end
        pause = 1'b0;

        for (int j = 1; j <= n_play; j++) begin
            in = hv[j-1];
            if (!hold) start = 1'($urandom_range(0, 1));
            if ((pcyc > 0) && (j == pafter + 1)) begin
                @(posedge clock);
                #1;
                pause = 1'b1;
                in    = 1'b1;
                for (int p = 0; p < pcyc; p++) begin
                    @(posedge clock);
                    #1;
                    check("pause_no_tick", sample_tick, 0);
                end
                check("pause_ticks_frozen", ticks_left, RT - pafter);
                check("pause_score_frozen", score, psum);
                pause = 1'b0;
                in    = hv[j-1];
            end
            wait_tick("play_tick", ok);
            if (!ok) return;
        end
        in = 1'b0;
        if (!hold) start = 1'b0;
        if (stop_at > 0) return;

        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(posedge clock);
            #1;
            ok = (state == 2'b11);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: state=%0d, expected 3 within 4 cycles", state);
            return;
        end
        @(posedge clock);
        #1;
        check("round_done_width", round_done, 0);
        check("done_hold_score", score, final_sc);
        check("done_ticks_left", ticks_left, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", state, 0);
        check("reset_score", score, 0);
        check("reset_high_score", high_score, 0);
        check("reset_ticks_left", ticks_left, 0);
        check("reset_sample_tick", sample_tick, 0);
        check("reset_round_done", round_done, 0);
        reset = 1'b0;

        run_round(5'b00011, 0, 1'b0, 0);
        run_round(5'b00000, 0, 1'b0, 0);
        run_round(5'b00000, 0, 1'b1, 0);
        repeat (ROUND_CYC + 10) @(posedge clock);
        #1;
        check("held_start_state", state, 3);
        check("held_start_ticks_left", ticks_left, 0);
        run_round(5'b10101, 0, 1'b0, 0);
        run_round(5'b11111, 0, 1'b0, 0);
        run_round(5'b11010, 10, 1'b0, 0);
        for (int r = 0; r < 12; r++) begin
            run_round(RT'($urandom), ((r % 2) != 0) ? int'($urandom_range(1, 12)) : 0, 1'b0, 0);
        end

        run_round(5'b00011, 0, 1'b0, 2);
        check("midplay_ticks_left", ticks_left, 3);
        check("midplay_score", score, 2);
        @(negedge clock);
        #1;
        reset = 1'b1;
        start = 1'b0;
        in    = 1'b0;
        @(posedge clock);
        #1;
        check("midreset_state", state, 0);
        check("midreset_score", score, 0);
        check("midreset_high_score", high_score, 0);
        check("midreset_ticks_left", ticks_left, 0);
        check("midreset_sample_tick", sample_tick, 0);
        check("midreset_round_done", round_done, 0);
        check("midreset_queue_drained", sbq.size(), 0);
        reset = 1'b0;
        sbq.delete();
        hs_model = 0;
        run_round(5'b00001, 0, 1'b0, 0);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
